// File: rtl/fetch_control_if.sv
// Fetch-stage control bundle: EX/ID hazard/branch inputs in, PC/pipe-register controls out.
// Latency: none, wires only. Backpressure: stalls travel as pc_stop/if_id_write/ex_hold.
interface fetch_control_if #(
    parameter int ADDR_W = 16
);
    logic              ex_branch_taken;
    logic [ADDR_W-1:0] ex_branch_target;
    logic              ex_mc_start;
    logic              id_load_use;
    logic              id_halt;

    logic              pc_stop;
    logic              pc_mux;
    logic [ADDR_W-1:0] branch_location;
    logic              if_id_write;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              ex_hold;
    logic              halted;
    logic [15:0]       stall_cycles;
    logic [15:0]       redirect_count;

    modport master (
        input  ex_branch_taken, ex_branch_target, ex_mc_start, id_load_use, id_halt,
        output pc_stop, pc_mux, branch_location, if_id_write, if_id_flush,
               id_ex_flush, ex_hold, halted, stall_cycles, redirect_count
    );

    modport slave (
        output ex_branch_taken, ex_branch_target, ex_mc_start, id_load_use, id_halt,
        input  pc_stop, pc_mux, branch_location, if_id_write, if_id_flush,
               id_ex_flush, ex_hold, halted, stall_cycles, redirect_count
    );
endinterface

// File: rtl/fetch_control.sv
// Pipeline-front controller: PC hold/redirect, IF/ID and ID/EX flush, multi-cycle and halt sequencing.
// Latency: outputs combinational from state + current inputs (zero-cycle branch redirect).
// Backpressure: stalls via pc_stop/if_id_write/ex_hold; FETCH_CTRL_PERF_EN adds perf counters.
module fetch_control #(
    parameter int ADDR_W       = 16,
    parameter int MC_CYCLES    = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clock,
    input  logic             reset,
    fetch_control_if.master  bus
);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MC_WAIT = 2'd1,
        S_DRAIN   = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    logic              pc_stop;
    logic              pc_mux;
    logic [ADDR_W-1:0] branch_location;
    logic              if_id_write;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              ex_hold;
    logic              halted;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pc_stop         = 1'b0;
        pc_mux          = 1'b0;
        branch_location = '0;
        if_id_write     = 1'b1;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        ex_hold         = 1'b0;
        halted          = 1'b0;

        case (state_q)
            S_RUN: begin
                // Branch wins: anything else visible this cycle is on the wrong path.
                if (bus.ex_branch_taken) begin
                    pc_mux          = 1'b1;
                    branch_location = bus.ex_branch_target;
                    if_id_flush     = 1'b1;
                    id_ex_flush     = 1'b1;
                end else if (bus.ex_mc_start) begin
                    pc_stop     = 1'b1;
                    if_id_write = 1'b0;
                    ex_hold     = 1'b1;
                    if (MC_CYCLES > 1) begin
                        state_d = S_MC_WAIT;
                        cnt_d   = 16'(MC_CYCLES - 1);
                    end
                end else if (bus.id_load_use) begin
                    pc_stop     = 1'b1;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (bus.id_halt) begin
                    pc_stop     = 1'b1;
                    if_id_flush = 1'b1;
                    state_d     = S_DRAIN;
                    cnt_d       = 16'(DRAIN_CYCLES);
                end
            end
            S_MC_WAIT: begin
                pc_stop     = 1'b1;
                if_id_write = 1'b0;
                ex_hold     = 1'b1;
                cnt_d       = cnt_q - 16'd1;
                if (cnt_q <= 16'd1) begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                pc_stop     = 1'b1;
                if_id_write = 1'b0;
                cnt_d       = cnt_q - 16'd1;
                if (cnt_q <= 16'd1) begin
                    state_d = S_HALTED;
                end
            end
            default: begin
                pc_stop     = 1'b1;
                if_id_write = 1'b0;
                halted      = 1'b1;
            end
        endcase

        // Reset silences every control, including the normally-high IF/ID enable.
        if (reset) begin
            state_d         = S_RUN;
            cnt_d           = '0;
            pc_stop         = 1'b0;
            pc_mux          = 1'b0;
            branch_location = '0;
            if_id_write     = 1'b0;
            if_id_flush     = 1'b0;
            id_ex_flush     = 1'b0;
            ex_hold         = 1'b0;
            halted          = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc_stop         = pc_stop;
    assign bus.pc_mux          = pc_mux;
    assign bus.branch_location = branch_location;
    assign bus.if_id_write     = if_id_write;
    assign bus.if_id_flush     = if_id_flush;
    assign bus.id_ex_flush     = id_ex_flush;
    assign bus.ex_hold         = ex_hold;
    assign bus.halted          = halted;

`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] redirect_count_q, redirect_count_d;

    // Saturating counters; the permanent HALTED stall is not counted.
    always_comb begin
        stall_cycles_d   = stall_cycles_q;
        redirect_count_d = redirect_count_q;
        if (pc_stop && (state_q != S_HALTED) && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        if (pc_mux && (redirect_count_q != 16'hFFFF)) begin
            redirect_count_d = redirect_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_q   <= '0;
            redirect_count_q <= '0;
        end else begin
            stall_cycles_q   <= stall_cycles_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign bus.stall_cycles   = stall_cycles_q;
    assign bus.redirect_count = redirect_count_q;
`else
    assign bus.stall_cycles   = 16'd0;
    assign bus.redirect_count = 16'd0;
`endif

endmodule
